// File: rtl/accumulator_alu_16bit_if.sv
// Command/result bus of the accumulator ALU: operand-side valid/ready command
// channel plus the registered accumulator/flag result channel.
interface accumulator_alu_16bit_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [15:0] D;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] Acc;
    logic        Sign;
    logic        Zero;
    logic        Carry;
    logic        Parity;
    logic        Overflow;
    logic        OvfSticky;

    modport master (
        output in_valid, op, D, out_ready,
        input  in_ready, out_valid, Acc, Sign, Zero, Carry, Parity, Overflow, OvfSticky
    );

    modport slave (
        input  in_valid, op, D, out_ready,
        output in_ready, out_valid, Acc, Sign, Zero, Carry, Parity, Overflow, OvfSticky
    );
endinterface

// File: rtl/accumulator_alu_16bit.sv
// Registered accumulator stage around a 16-bit flagged adder with a one-deep
// valid/ready output slot; supports ADC/SBB chaining and sticky overflow.
module accumulator_alu_16bit #(
    parameter logic [15:0] ACC_INIT = 16'h0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    accumulator_alu_16bit_if.slave bus
);
    localparam int unsigned W = 16;

    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_ADC  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_SBB  = 3'b101;
    localparam logic [2:0] OP_CLR  = 3'b110;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t         state;
    state_t         state_nxt;
    logic           ready_c;
    logic           accept_c;

    logic [W-1:0]   acc;
    logic           sign;
    logic           zero;
    logic           carry;
    logic           parity;
    logic           ovf;
    logic           ovf_sticky;

    logic [W-1:0]   add_b;
    logic           add_cin;
    logic           is_arith;
    logic [W-1:0]   add_z;
    logic           add_sign;
    logic           add_zero;
    logic           add_carry;
    logic           add_parity;
    logic           add_ovf;

    // Output-slot state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nxt;
    end

    // Next state: fill on accept, drain on consume without a replacement
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (accept_c) state_nxt = FULL;
            FULL:    if (bus.out_ready && !accept_c) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    // Handshake decode; in_ready is deliberately combinational on out_ready
    always_comb begin
        bus.out_valid = (state == FULL);
        ready_c       = (state == EMPTY) || bus.out_ready;
        bus.in_ready  = ready_c;
        accept_c      = bus.in_valid && ready_c;
    end

    // Adder operand select; subtraction uses ~D with the carry as not-borrow
    always_comb begin
        add_b    = bus.D;
        add_cin  = 1'b0;
        is_arith = 1'b0;
        case (bus.op)
            OP_ADD: begin is_arith = 1'b1; end
            OP_ADC: begin is_arith = 1'b1; add_cin = carry; end
            OP_SUB: begin is_arith = 1'b1; add_b = ~bus.D; add_cin = 1'b1; end
            OP_SBB: begin is_arith = 1'b1; add_b = ~bus.D; add_cin = carry; end
            default: ;
        endcase
    end

    fullAdder_16bit u_adder (
        .A        (acc),
        .B        (add_b),
        .Cin      (add_cin),
        .Z        (add_z),
        .Sign     (add_sign),
        .Zero     (add_zero),
        .Carry    (add_carry),
        .Parity   (add_parity),
        .Overflow (add_ovf)
    );

    // Accumulator and flags; only an accepted command changes them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= ACC_INIT;
            sign       <= 1'b0;
            zero       <= 1'b0;
            carry      <= 1'b0;
            parity     <= 1'b0;
            ovf        <= 1'b0;
            ovf_sticky <= 1'b0;
        end else if (accept_c) begin
            if (is_arith) begin
                acc        <= add_z;
                sign       <= add_sign;
                zero       <= add_zero;
                carry      <= add_carry;
                parity     <= add_parity;
                ovf        <= add_ovf;
                ovf_sticky <= ovf_sticky | add_ovf;
            end else if (bus.op == OP_LOAD) begin
                acc    <= bus.D;
                sign   <= bus.D[W-1];
                zero   <= (bus.D == W'(0));
                parity <= ~^bus.D;
                carry  <= 1'b0;
                ovf    <= 1'b0;
            end else if (bus.op == OP_CLR) begin
                acc        <= W'(0);
                sign       <= 1'b0;
                zero       <= 1'b1;
                parity     <= 1'b1;
                carry      <= 1'b0;
                ovf        <= 1'b0;
                ovf_sticky <= 1'b0;
            end
        end
    end

    assign bus.Acc       = acc;
    assign bus.Sign      = sign;
    assign bus.Zero      = zero;
    assign bus.Carry     = carry;
    assign bus.Parity    = parity;
    assign bus.Overflow  = ovf;
    assign bus.OvfSticky = ovf_sticky;
endmodule

// Combinational 16-bit adder with sign/zero/carry/even-parity/overflow flags
module fullAdder_16bit (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Cin,
    output logic [15:0] Z,
    output logic        Sign,
    output logic        Zero,
    output logic        Carry,
    output logic        Parity,
    output logic        Overflow
);
    logic [16:0] sum;

    assign sum      = 17'(A) + 17'(B) + 17'(Cin);
    assign Z        = sum[15:0];
    assign Carry    = sum[16];
    assign Sign     = sum[15];
    assign Zero     = (sum[15:0] == 16'h0000);
    assign Parity   = ~^sum[15:0];
    // Signed overflow: like-signed operands producing an opposite-signed sum
    assign Overflow = (A[15] == B[15]) && (sum[15] != A[15]);
endmodule
